fifo_wptr_full: RTL and testbench
=================================

// Module: fifo_wptr_full
// PURPOSE
//  Write-side pointer and full-flag generator for the async FIFO. Lives in the write clock domain.
//  Produces the binary RAM write address and the registered Gray write pointer.
//  The Gray write pointer is launched into the read domain through the two-flop synchronizer.
//  Consumes the read pointer after it has been synchronized back into this domain.
//  Derives full, almost_full, occupancy and a sticky overflow error from those pointers.
// PARAMETERS
//  Datawidth    8  FIFO word width (carried for consistency; no data path in this block)
//  Width        3  address bits; pointers are Width+1 bits (extra wrap bit); Width >= 2
//  Depth        8  entries, must equal 2**Width
//  AFULL_THRESH 6  occupancy at or above which almost_full asserts (1..Depth)
// PORTS
//  clk          in   1        write-domain clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  w_en         in   1        write request from producer
//  rptr_sync    in   Width+1  Gray read pointer, already 2-flop synchronized into clk domain
//  wptr         out  Width+1  registered Gray write pointer (to synchronizer input)
//  waddr        out  Width    RAM write address = wbin[Width-1:0]
//  wr_ack       out  1        combinational: w_en & ~full (write accepted this cycle)
//  full         out  1        registered full flag
//  almost_full  out  1        registered, wcount >= AFULL_THRESH
//  wcount       out  Width+1  registered occupancy as seen by writer (0..Depth)
//  overflow     out  1        sticky: a write was attempted while full
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is asynchronous and active-high.
//  - Reset (async assert, sync release expected upstream):
//    wbin=0, wptr=0, full=0, almost_full=0, wcount=0, overflow=0.
//  - Write acceptance: accept when w_en=1 and full=0.
//    wbin_next = wbin + accept (modulo 2**(Width+1)).
//    wgray_next = (wbin_next>>1) ^ wbin_next.
//  - Register on every clk edge: wbin<=wbin_next; wptr<=wgray_next. wptr changes by exactly one bit per accept.
//    All outputs except wr_ack and waddr are registers; waddr follows wbin with no extra delay.
//  - full <= (wgray_next == {~rptr_sync[Width:Width-1], rptr_sync[Width-2:0]}).
//    Asserts the cycle after the Depth-th outstanding write is accepted.
//  - rbin_s = gray_to_bin(rptr_sync).
//    wcount <= wbin_next - rbin_s (Width+1-bit modular subtraction; result is always 0..Depth).
//  - almost_full <= (wbin_next - rbin_s) >= AFULL_THRESH.
//  - overflow <= overflow | (w_en & full). Cleared only by rst.
//    A write attempted while full is dropped; wbin and wptr hold.
//  - Simultaneous write accept + rptr_sync advance:
//    - Both are used in the same next-state compare.
//    - full stays 0 if net occupancy stays below Depth.
//  - Full release: when rptr_sync advances, full deasserts on the next clk edge, even if w_en=0.
//    This is conservative, because rptr_sync lags the true read pointer by 2+ cycles.
//  - Wrap-around: wbin rolls from 2**(Width+1)-1 to 0 with no special-casing; the Gray wrap is also single-bit.
//  - Reset mid-operation: all state returns to reset values immediately.
//    The read side must be reset together with this block.
// STRUCTURE
//  - Package fifo_pkg: the functions bin2gray/gray2bin, parametrised by Width.
//  - Sub-module gray_to_bin (pure combinational, XOR prefix), instantiated once for rptr_sync.
//  - Top level: the pointer register pair, the full, almost_full and wcount registers, and the overflow sticky register.
// TESTING (Width=3, Depth=8, AFULL_THRESH=6)
//  1 Reset, then rst=0 with w_en=0 -> wptr=0, waddr=0, full=0, wcount=0, overflow=0.
//  2 rptr_sync=0, w_en=1 for 8 cycles -> wptr = 1,3,2,6,7,5,4,C; almost_full=1 after 6th write; full=1 after 8th.
//  3 While full, w_en=1 for 2 cycles -> wr_ack=0, wptr holds C, waddr=0, overflow=1 and stays 1.
//  4 While full, set rptr_sync=1 (bin 1) -> full=0 next edge, wcount=7; next write gives full=1 and wptr=D.
//  5 Stream with rptr_sync tracking wptr delayed by 3 cycles over 40 writes ->
//    wbin wraps past 15->0; full never asserts; wcount <= 3; every wptr step is a 1-bit change (checker).
//  6 Assert rst mid-burst (wcount=5) -> all outputs are 0 before the next clk edge; writes resume from waddr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Gray/binary conversion helpers shared by the async FIFO pointer blocks.
package fifo_pkg;

    localparam int unsigned FN_W = 32;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Only the low 'width' bits of g take part in the prefix XOR.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g,
                                                 input int unsigned     width);
        logic [FN_W-1:0] b;
        logic            acc;
        b   = '0;
        acc = 1'b0;
        for (int i = int'(FN_W) - 1; i >= 0; i--) begin
            acc  = acc ^ ((i < int'(width)) ? g[i] : 1'b0);
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full/almost-full/occupancy/overflow generator for the async FIFO.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned Datawidth    = 8,
    parameter int unsigned Width        = 3,
    parameter int unsigned Depth        = 8,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [Width:0]   rptr_sync,
    output logic [Width:0]   wptr,
    output logic [Width-1:0] waddr,
    output logic             wr_ack,
    output logic             full,
    output logic             almost_full,
    output logic [Width:0]   wcount,
    output logic             overflow
);

    localparam int unsigned PW = Width + 1;

    if (Datawidth < 1 || Width < 2 || Depth != (1 << Width) ||
        AFULL_THRESH < 1 || AFULL_THRESH > Depth) begin : g_bad_cfg
        $error("fifo_wptr_full: illegal parameter combination");
    end

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] occ_next;
    logic [PW-1:0] rptr_full_cmp;
    logic          accept;
    logic          full_next;
    logic          afull_next;

    gray_to_bin #(.N(PW)) u_rptr_g2b (
        .gray (rptr_sync),
        .bin  (rbin_s)
    );

    // A full FIFO's write pointer equals the read pointer with its two MSBs inverted (Gray form).
    always_comb begin
        accept        = w_en & ~full;
        wbin_next     = wbin + PW'(accept);
        wgray_next    = PW'(bin2gray(FN_W'(wbin_next)));
        rptr_full_cmp = {~rptr_sync[Width:Width-1], rptr_sync[Width-2:0]};
        full_next     = (wgray_next == rptr_full_cmp);
        occ_next      = wbin_next - rbin_s;
        afull_next    = (occ_next >= PW'(AFULL_THRESH));
    end

    assign wr_ack = accept;
    assign waddr  = wbin[Width-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wcount      <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= full_next;
            almost_full <= afull_next;
            wcount      <= occ_next;
            overflow    <= overflow | (w_en & full);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: vector table, reference model with scoreboard, corner sequences.
module tb_fifo_wptr_full;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic [3:0] rptr_sync;
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       wr_ack;
    logic       full;
    logic       almost_full;
    logic [3:0] wcount;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] wptr;
        logic [2:0] waddr;
        logic       full;
        logic       af;
        logic [3:0] cnt;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       we;
        logic [3:0] rs;
        logic       ack;
        exp_t       e;
    } vec_t;

    exp_t sb[$];

    // reference model state
    logic [3:0] mbin;
    logic       mfull;
    logic       movf;

    fifo_wptr_full #(
        .Datawidth    (8),
        .Width        (3),
        .Depth        (8),
        .AFULL_THRESH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .rptr_sync   (rptr_sync),
        .wptr        (wptr),
        .waddr       (waddr),
        .wr_ack      (wr_ack),
        .full        (full),
        .almost_full (almost_full),
        .wcount      (wcount),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    endfunction

    // Compare registered outputs against the oldest scoreboard entry.
    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(1), 32'(0));
            return;
        end
        e = sb.pop_front();
        chk("wptr",        32'(wptr),        32'(e.wptr));
        chk("waddr",       32'(waddr),       32'(e.waddr));
        chk("full",        32'(full),        32'(e.full));
        chk("almost_full", 32'(almost_full), 32'(e.af));
        chk("wcount",      32'(wcount),      32'(e.cnt));
        chk("overflow",    32'(overflow),    32'(e.ovf));
    endtask

    // Entered one time unit after a rising edge; leaves one unit after the next.
    task automatic apply(input logic we, input logic [3:0] rs, input logic ack, input exp_t e);
        w_en      = we;
        rptr_sync = rs;
        #1;
        chk("wr_ack", 32'(wr_ack), 32'(ack));
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic model_reset();
        mbin  = 4'd0;
        mfull = 1'b0;
        movf  = 1'b0;
    endtask

    // Advance the model by one clock; returns the acknowledge and post-edge expectations.
    task automatic model_step(input logic we, input logic [3:0] rs, output logic ack, output exp_t e);
        logic [3:0] nb;
        logic [3:0] occ;
        ack   = we & ~mfull;
        nb    = mbin + {3'd0, ack};
        occ   = nb - g2b(rs);
        movf  = movf | (we & mfull);
        mfull = (b2g(nb) == (rs ^ 4'b1100));
        mbin  = nb;
        e.wptr  = b2g(nb);
        e.waddr = nb[2:0];
        e.full  = mfull;
        e.af    = (occ >= 4'd6);
        e.cnt   = occ;
        e.ovf   = movf;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        w_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    vec_t vecs[14];

    initial begin
        logic       ack;
        exp_t       e;
        logic [3:0] hist[$];
        logic [3:0] prev;
        logic [3:0] rs;

        rst       = 1'b1;
        w_en      = 1'b0;
        rptr_sync = 4'd0;
        model_reset();

        // write burst to full, overflow attempts, then full release by read advance
        vecs[0]  = '{1'b0, 4'h0, 1'b0, '{4'h0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0}};
        vecs[1]  = '{1'b1, 4'h0, 1'b1, '{4'h1, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0}};
        vecs[2]  = '{1'b1, 4'h0, 1'b1, '{4'h3, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0}};
        vecs[3]  = '{1'b1, 4'h0, 1'b1, '{4'h2, 3'd3, 1'b0, 1'b0, 4'd3, 1'b0}};
        vecs[4]  = '{1'b1, 4'h0, 1'b1, '{4'h6, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0}};
        vecs[5]  = '{1'b1, 4'h0, 1'b1, '{4'h7, 3'd5, 1'b0, 1'b0, 4'd5, 1'b0}};
        vecs[6]  = '{1'b1, 4'h0, 1'b1, '{4'h5, 3'd6, 1'b0, 1'b1, 4'd6, 1'b0}};
        vecs[7]  = '{1'b1, 4'h0, 1'b1, '{4'h4, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0}};
        vecs[8]  = '{1'b1, 4'h0, 1'b1, '{4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0}};
        vecs[9]  = '{1'b1, 4'h0, 1'b0, '{4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1}};
        vecs[10] = '{1'b1, 4'h0, 1'b0, '{4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1}};
        vecs[11] = '{1'b0, 4'h0, 1'b0, '{4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1}};
        vecs[12] = '{1'b0, 4'h1, 1'b0, '{4'hC, 3'd0, 1'b0, 1'b1, 4'd7, 1'b1}};
        vecs[13] = '{1'b1, 4'h1, 1'b1, '{4'hD, 3'd1, 1'b1, 1'b1, 4'd8, 1'b1}};

        // reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_wptr",     32'(wptr),        32'(0));
        chk("rst_waddr",    32'(waddr),       32'(0));
        chk("rst_full",     32'(full),        32'(0));
        chk("rst_afull",    32'(almost_full), 32'(0));
        chk("rst_wcount",   32'(wcount),      32'(0));
        chk("rst_overflow", 32'(overflow),    32'(0));
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i].we, vecs[i].rs, vecs[i].ack, vecs[i].e);

        // streaming with the read pointer lagging three cycles behind
        do_reset();
        prev = wptr;
        for (int k = 0; k < 40; k++) begin
            rs = (hist.size() >= 3) ? hist[hist.size() - 3] : 4'd0;
            model_step(1'b1, rs, ack, e);
            apply(1'b1, rs, ack, e);
            hist.push_back(e.wptr);
            chk("stream_onebit", 32'($countones(wptr ^ prev)), 32'(1));
            chk("stream_le3", 32'(wcount <= 4'd3), 32'(1));
            prev = wptr;
        end
        chk("stream_wrapped_bin", 32'(mbin), 32'(8));

        // reset asserted mid-burst
        do_reset();
        for (int k = 0; k < 5; k++) begin
            model_step(1'b1, 4'd0, ack, e);
            apply(1'b1, 4'd0, ack, e);
        end
        chk("pre_rst_wcount", 32'(wcount), 32'(5));
        #2;
        rst = 1'b1;
        #1;
        chk("async_wptr",     32'(wptr),        32'(0));
        chk("async_waddr",    32'(waddr),       32'(0));
        chk("async_full",     32'(full),        32'(0));
        chk("async_afull",    32'(almost_full), 32'(0));
        chk("async_wcount",   32'(wcount),      32'(0));
        chk("async_overflow", 32'(overflow),    32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("resume_waddr0", 32'(waddr), 32'(0));
        model_step(1'b1, 4'd0, ack, e);
        apply(1'b1, 4'd0, ack, e);
        w_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
